// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer
//   Buffers CPU LCD command/data writes in a small FIFO and replays them onto
//   HD44780-style pins with setup / enable pulse / hold / execution-wait timing,
//   so software can issue back-to-back stores without delay loops.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_valid/wr_ready     CPU write handshake (accept on valid && ready)
//   wr_rs, wr_data        0 = command / 1 = data, byte to send
//   busy                  FIFO non-empty or a transfer/exec wait in progress
//   lcd_data              LCD data bus
//   lcd_ctrl              [1] = RS, [0] = RW (always 0)
//   lcd_enable            LCD E strobe (registered)
//
// Optional build macro LCD_INIT_SEQ_EN: after reset, replay the built-in
//   init commands 0x38, 0x0C, 0x06, 0x01 before accepting CPU writes.
module lcd_write_sequencer #(
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 4,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 40,
  parameter int LONG_EXEC_CYC = 1640,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic [1:0] lcd_ctrl,
  output logic       lcd_enable
);
  localparam int CNT_W = $clog2(LONG_EXEC_CYC + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } wr_req_t;

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, EXEC
`ifdef LCD_INIT_SEQ_EN
    , INIT
`endif
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                en_nxt, load, pop, push, full, long_cmd;
  wr_req_t             load_req;
  wr_req_t [FIFO_DEPTH-1:0] mem;
  logic [AW-1:0]       wptr, rptr;
  logic [AW:0]         count;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign busy     = (state != IDLE) || (count != '0);
  // Clear and home commands need the long execution wait.
  assign long_cmd = !lcd_ctrl[1] && (lcd_data inside {8'h01, 8'h02, 8'h03});

`ifdef LCD_INIT_SEQ_EN
  logic [2:0] init_idx;   // next built-in command; 4 = all issued
  logic       init_done;  // set when the last init exec wait finishes

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  assign wr_ready = !full && init_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_idx  <= 3'd0;
      init_done <= 1'b0;
    end else begin
      if (state == INIT) init_idx <= init_idx + 3'd1;
      if (state == EXEC && cnt == CNT_W'(1) && init_idx == 3'd4) init_done <= 1'b1;
    end
  end
`else
  assign wr_ready = !full;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    en_nxt    = lcd_enable;
    load      = 1'b0;
    pop       = 1'b0;
    load_req  = mem[rptr];
    case (state)
      IDLE: if (count != '0) begin
        pop       = 1'b1;
        load      = 1'b1;
        state_nxt = SETUP;
        cnt_nxt   = CNT_W'(SETUP_CYC);
      end
`ifdef LCD_INIT_SEQ_EN
      INIT: begin
        load      = 1'b1;
        load_req  = '{rs: 1'b0, data: init_cmd(init_idx[1:0])};
        state_nxt = SETUP;
        cnt_nxt   = CNT_W'(SETUP_CYC);
      end
`endif
      SETUP: if (cnt == CNT_W'(1)) begin
        state_nxt = PULSE;
        cnt_nxt   = CNT_W'(PULSE_CYC);
        en_nxt    = 1'b1;
      end else cnt_nxt = cnt - CNT_W'(1);
      PULSE: if (cnt == CNT_W'(1)) begin
        state_nxt = HOLD;
        cnt_nxt   = CNT_W'(HOLD_CYC);
        en_nxt    = 1'b0;
      end else cnt_nxt = cnt - CNT_W'(1);
      HOLD: if (cnt == CNT_W'(1)) begin
        state_nxt = EXEC;
        cnt_nxt   = long_cmd ? CNT_W'(LONG_EXEC_CYC) : CNT_W'(EXEC_CYC);
      end else cnt_nxt = cnt - CNT_W'(1);
      EXEC: if (cnt == CNT_W'(1)) begin
`ifdef LCD_INIT_SEQ_EN
        state_nxt = (init_idx != 3'd4) ? INIT : IDLE;
`else
        state_nxt = IDLE;
`endif
        cnt_nxt   = '0;
      end else cnt_nxt = cnt - CNT_W'(1);
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        en_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef LCD_INIT_SEQ_EN
      state <= INIT;
`else
      state <= IDLE;
`endif
      cnt        <= '0;
      count      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      lcd_data   <= 8'h00;
      lcd_ctrl   <= 2'b00;
      lcd_enable <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      lcd_enable <= en_nxt;
      if (load) begin
        lcd_data <= load_req.data;
        lcd_ctrl <= {load_req.rs, 1'b0};
      end
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{rs: wr_rs, data: wr_data};
  end
endmodule

// File: tb/tb_lcd_write_sequencer.sv
module tb_lcd_write_sequencer;
  localparam int S = 2, P = 4, H = 2, E = 40, L = 1640, D = 4;

  logic clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0, wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic wr_ready, busy, lcd_enable;
  logic [7:0] lcd_data;
  logic [1:0] lcd_ctrl;
  int checks = 0, errors = 0;

  // Reference model: timestamps of each transfer rather than a state machine.
  int q[$];
  longint cyc, t_pop, end_t;
  logic [8:0] cur;

  wire [12:0] obs = {lcd_data, lcd_ctrl, lcd_enable, busy, wr_ready};

  lcd_write_sequencer dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_rs(wr_rs), .wr_data(wr_data), .busy(busy), .lcd_data(lcd_data),
    .lcd_ctrl(lcd_ctrl), .lcd_enable(lcd_enable)
  );

  always #5 clk = ~clk;

  function automatic int exec_of(input logic [8:0] e);
    return (!e[8] && e[7:0] >= 8'h01 && e[7:0] <= 8'h03) ? L : E;
  endfunction

  function automatic logic [12:0] exp_vec();
    logic en, bsy, rdy;
    en  = (cyc >= t_pop + S) && (cyc < t_pop + S + P);
    bsy = (q.size() != 0) || (cyc < end_t);
    rdy = q.size() < D;
    return {cur[7:0], cur[8], 1'b0, en, bsy, rdy};
  endfunction

  task automatic model_reset();
    q.delete();
    cyc = 0; t_pop = -1000; end_t = -1; cur = 9'h000;
  endtask

  // Drive inputs for one edge, advance the model across that edge, and
  // return at the following negedge where outputs are sampled.
  task automatic tick(input logic v, input logic rs, input logic [7:0] d, output logic acc);
    longint t;
    logic pre_ready;
    wr_valid = v; wr_rs = rs; wr_data = d;
    t = cyc + 1;
    pre_ready = q.size() < D;
    if (cyc >= end_t && q.size() > 0) begin
      cur   = 9'(q.pop_front());
      t_pop = t;
      end_t = t + S + P + H + exec_of(cur);
    end
    acc = v && pre_ready;
    if (acc) q.push_back(int'({rs, d}));
    cyc = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic acc;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 13'h001) begin errors++; $display("FAIL reset_state got %h want %h", obs, 13'h001); end
    @(negedge clk); @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 8'h00, acc);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
    end
  endtask

  task automatic test_single();
    logic acc;
    int rise_k = -1, width = 0, drop_k = -1;
    tick(1'b1, 1'b1, 8'h41, acc);
    for (int k = 1; k <= 60; k++) begin
      tick(1'b0, 1'b0, 8'h00, acc);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL single cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
      if (k == 1) begin
        checks++;
        if ({lcd_ctrl, lcd_data} !== 10'h241) begin errors++; $display("FAIL single_latch got %h want %h", {lcd_ctrl, lcd_data}, 10'h241); end
      end
      if (lcd_enable) begin width++; if (rise_k < 0) rise_k = k; end
      if (!busy && drop_k < 0) drop_k = k;
    end
    checks++;
    if (rise_k != 1 + S || width != P) begin errors++; $display("FAIL single_strobe rise=%0d width=%0d want %0d %0d", rise_k, width, 1 + S, P); end
    checks++;
    if (drop_k != 1 + S + P + H + E) begin errors++; $display("FAIL single_busy drop=%0d want %0d", drop_k, 1 + S + P + H + E); end
  endtask

  task automatic test_exec_len(input logic [7:0] cmd, input int want);
    logic acc;
    int drop_k = -1;
    tick(1'b1, 1'b0, cmd, acc);
    for (int k = 1; k <= 1 + S + P + H + L + 5 && drop_k < 0; k++) begin
      tick(1'b0, 1'b0, 8'h00, acc);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL exec_%h cyc=%0d got %h want %h", cmd, cyc, obs, exp_vec()); end
      if (!busy) drop_k = k;
    end
    checks++;
    if (drop_k != 1 + S + P + H + want) begin errors++; $display("FAIL exec_len_%h busy=%0d want %0d", cmd, drop_k, 1 + S + P + H + want); end
  endtask

  task automatic test_back_to_back();
    logic acc, prev_en = 1'b0;
    int idx = 0, ns = 0;
    for (int k = 0; k < 320; k++) begin
      if (idx < 5) tick(1'b1, 1'b1, 8'h10 + 8'(idx), acc);
      else if (k < 15) tick(1'b1, 1'b1, 8'h15, acc);
      else tick(1'b0, 1'b0, 8'h00, acc);
      if (acc) idx++;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL b2b cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
      if (k == 4 || k == 10) begin
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_full k=%0d wr_ready=%b want 0", k, wr_ready); end
      end
      if (lcd_enable && !prev_en) begin
        checks++;
        if (lcd_data !== 8'h10 + 8'(ns)) begin errors++; $display("FAIL b2b_order strobe %0d got %h want %h", ns, lcd_data, 8'h10 + 8'(ns)); end
        ns++;
      end
      prev_en = lcd_enable;
    end
    checks++;
    if (ns != 5) begin errors++; $display("FAIL b2b_count got %0d want 5", ns); end
  endtask

  task automatic test_push_pop();
    logic acc, prev_en = 1'b0;
    int ns = 0, guard = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'hA0 + 8'(i), acc);
    while (cyc < end_t && guard < 100) begin
      tick(1'b0, 1'b0, 8'h00, acc);
      guard++;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL pushpop_wait cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
      if (lcd_enable && !prev_en) ns++;
      prev_en = lcd_enable;
    end
    // This edge pops A1 while A3 is pushed: occupancy stays at 2.
    tick(1'b1, 1'b0, 8'hA3, acc);
    tick(1'b1, 1'b0, 8'hA4, acc);
    tick(1'b1, 1'b0, 8'hA5, acc);
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL pushpop_full wr_ready=%b want 0", wr_ready); end
    tick(1'b1, 1'b0, 8'hA6, acc);
    for (int k = 0; k < 300; k++) begin
      tick(1'b0, 1'b0, 8'h00, acc);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL pushpop cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
      if (lcd_enable && !prev_en) begin
        checks++;
        if (lcd_data !== 8'hA0 + 8'(ns)) begin errors++; $display("FAIL pushpop_order strobe %0d got %h want %h", ns, lcd_data, 8'hA0 + 8'(ns)); end
        ns++;
      end
      prev_en = lcd_enable;
    end
    checks++;
    if (ns != 6) begin errors++; $display("FAIL pushpop_count got %0d want 6", ns); end
  endtask

  task automatic test_random();
    logic acc, v, rs;
    logic [7:0] d;
    int guard = 0;
    for (int k = 0; k < 2500; k++) begin
      v  = $urandom_range(0, 99) < 30;
      rs = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      if (!rs && d <= 8'h03 && $urandom_range(0, 3) != 0) d = 8'h80;
      tick(v, rs, d, acc);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
    end
    while ((q.size() != 0 || cyc < end_t) && guard < 12000) begin
      tick(1'b0, 1'b0, 8'h00, acc);
      guard++;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random_drain cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL random_idle busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset();
    logic acc;
    int guard = 0;
    tick(1'b1, 1'b1, 8'h55, acc);
    while (!lcd_enable && guard < 10) begin tick(1'b0, 1'b0, 8'h00, acc); guard++; end
    checks++;
    if (lcd_enable !== 1'b1) begin errors++; $display("FAIL areset_pulse lcd_enable=%b want 1", lcd_enable); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 13'h001) begin errors++; $display("FAIL areset_async got %h want %h", obs, 13'h001); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 8'h00, acc);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL areset_after cyc=%0d got %h want %h", cyc, obs, exp_vec()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_exec_len(8'h01, L);
    test_exec_len(8'h80, E);
    test_back_to_back();
    test_push_pop();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
